spi_cmd_decoder: RTL and testbench
==================================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have port i_sys_clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-002 SHALL have port i_rst_b, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port i_rx_byte, input, 8 bits: byte received from the SPI slave PHY.
REQ-004 SHALL have port i_rx_valid, input, 1 bit: one-cycle strobe qualifying i_rx_byte.
REQ-005 SHALL have port i_frame_active, input, 1 bit: high while the SPI chip-select is asserted (already synchronised).
REQ-006 SHALL have ports i_rd_data_sys, i_rd_data_io and i_rd_data_smi, inputs, 8 bits each: read-back data from each target module.
REQ-007 SHALL have port o_ioc, output, 5 bits: latched IOC field.
REQ-008 SHALL have port o_data_out, output, 8 bits: latched write data.
REQ-009 SHALL have ports o_cs_sys, o_cs_io and o_cs_smi, outputs, 1 bit each: per-module select.
REQ-010 SHALL have ports o_fetch_cmd and o_load_cmd, outputs, 1 bit each: read and write strobes.
REQ-011 SHALL have port o_tx_byte, output, 8 bits: reply byte to the PHY; o_tx_load, output, 1 bit: strobe qualifying o_tx_byte.
REQ-012 SHALL have port o_err_count, output, 8 bits: saturating count of rejected commands.

Function
REQ-013 SHALL decode the first byte of a frame as the command byte: bit7 = 1 read / 0 write; bits6:5 = module (00 sys, 01 io, 10 smi, 11 invalid); bits4:0 = IOC.
REQ-014 SHALL implement the states IDLE, DATA_W, READ_F, READ_C and WAIT_END.
REQ-015 In IDLE with i_rx_valid and i_frame_active high at edge t, SHALL latch o_ioc and drive the selected o_cs_* high from cycle t+1.
REQ-016 For a write command, SHALL go IDLE->DATA_W.
REQ-017 For a read command, SHALL go IDLE->READ_F and drive o_fetch_cmd high for exactly cycle t+1.
REQ-018 SHALL go READ_F->READ_C, then in cycle t+3 register the selected i_rd_data_* into o_tx_byte with o_tx_load high for one cycle, then go to WAIT_END.
REQ-019 In DATA_W, on i_rx_valid at edge u, SHALL drive o_data_out = byte and o_load_cmd = 1 for exactly cycle u+1, then go to WAIT_END.
REQ-020 For a module field of 11, SHALL assert no o_cs_*, emit no strobe, increment o_err_count (saturating at 255) and go to WAIT_END.
REQ-021 In WAIT_END, SHALL ignore further bytes with no strobes.
REQ-022 At most one o_cs_* SHALL be high at any time; the select SHALL stay high until the state machine returns to IDLE.
REQ-023 i_frame_active low in any state SHALL force IDLE at the next edge and drop all o_cs_* the same cycle.
REQ-024 If a frame ends in DATA_W with no data byte, no o_load_cmd SHALL be issued; a frame ending in READ_F/READ_C SHALL suppress o_tx_load.
REQ-025 i_rx_valid while i_frame_active is low SHALL be ignored.
REQ-026 o_fetch_cmd and o_load_cmd SHALL never be high in the same cycle.
REQ-027 o_err_count SHALL never wrap.

Reset
REQ-028 With i_rst_b low at an edge, SHALL set state IDLE and clear all outputs to 0 (o_ioc, o_data_out, o_cs_*, strobes, o_tx_byte, o_tx_load, o_err_count).
REQ-029 Reset SHALL take priority over every other event, including mid-frame, and SHALL abort any pending strobe.

Verification
REQ-030 Write: frame with bytes 0x06, 0x5A -> o_cs_sys=1, o_ioc=0x06, o_load_cmd one cycle with o_data_out=0x5A, o_cs_sys=0 after the frame ends.
REQ-031 Read: frame with 0xA3 and i_rd_data_io=0xC4 -> o_cs_io=1, o_fetch_cmd at t+1, o_tx_load at t+3 with o_tx_byte=0xC4.
REQ-032 Invalid: 0x60 x 256 frames -> no cs or strobe, o_err_count stops at 0xFF.
REQ-033 Abort: 0x05 then i_frame_active low before data -> no o_load_cmd, state IDLE, o_cs_sys=0.
REQ-034 Extra bytes: 0x06, 0x11, 0x22, 0x33 -> exactly one o_load_cmd with data 0x11.
REQ-035 Reset mid-read: i_rst_b low in cycle t+1 of a read -> no o_tx_load, all outputs 0.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: the first byte of each frame selects a target module and a read or write.
// Writes take the next byte as data; reads return one byte fetched from the selected module.
module spi_cmd_decoder (
  input  logic       i_sys_clk,
  input  logic       i_rst_b,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  input  logic       i_frame_active,
  input  logic [7:0] i_rd_data_sys,
  input  logic [7:0] i_rd_data_io,
  input  logic [7:0] i_rd_data_smi,
  output logic [4:0] o_ioc,
  output logic [7:0] o_data_out,
  output logic       o_cs_sys,
  output logic       o_cs_io,
  output logic       o_cs_smi,
  output logic       o_fetch_cmd,
  output logic       o_load_cmd,
  output logic [7:0] o_tx_byte,
  output logic       o_tx_load,
  output logic [7:0] o_err_count,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DATA_W   = 3'd1,
    ST_READ_F   = 3'd2,
    ST_READ_C   = 3'd3,
    ST_WAIT_END = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] ioc_q, ioc_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cs_q, cs_d;          // {smi, io, sys}
  logic       fetch_q, fetch_d;
  logic       load_q, load_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_load_q, tx_load_d;
  logic [7:0] err_q, err_d;

  logic       cmd_rd;
  logic [1:0] cmd_mod;

  assign cmd_rd  = i_rx_byte[7];
  assign cmd_mod = i_rx_byte[6:5];

  // State register and all registered outputs
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_b) begin
      state_q   <= ST_IDLE;
      ioc_q     <= '0;
      data_q    <= '0;
      cs_q      <= '0;
      fetch_q   <= 1'b0;
      load_q    <= 1'b0;
      tx_byte_q <= '0;
      tx_load_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ioc_q     <= ioc_d;
      data_q    <= data_d;
      cs_q      <= cs_d;
      fetch_q   <= fetch_d;
      load_q    <= load_d;
      tx_byte_q <= tx_byte_d;
      tx_load_q <= tx_load_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; a dropped chip-select always returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!i_frame_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (cmd_mod == 2'b11) state_d = ST_WAIT_END;
            else if (cmd_rd)      state_d = ST_READ_F;
            else                  state_d = ST_DATA_W;
          end
        end
        ST_DATA_W:   if (i_rx_valid) state_d = ST_WAIT_END;
        ST_READ_F:   state_d = ST_READ_C;
        ST_READ_C:   state_d = ST_WAIT_END;
        ST_WAIT_END: state_d = ST_WAIT_END;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic; strobes default low so each is a single-cycle pulse
  always_comb begin
    ioc_d     = ioc_q;
    data_d    = data_q;
    cs_d      = cs_q;
    fetch_d   = 1'b0;
    load_d    = 1'b0;
    tx_byte_d = tx_byte_q;
    tx_load_d = 1'b0;
    err_d     = err_q;
    if (!i_frame_active) begin
      cs_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            ioc_d = i_rx_byte[4:0];
            case (cmd_mod)
              2'b00:   cs_d = 3'b001;
              2'b01:   cs_d = 3'b010;
              2'b10:   cs_d = 3'b100;
              default: cs_d = 3'b000;
            endcase
            if (cmd_mod == 2'b11) begin
              err_d = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end else begin
              fetch_d = cmd_rd;
            end
          end
        end
        ST_DATA_W: begin
          if (i_rx_valid) begin
            data_d = i_rx_byte;
            load_d = 1'b1;
          end
        end
        ST_READ_C: begin
          case (cs_q)
            3'b001:  tx_byte_d = i_rd_data_sys;
            3'b010:  tx_byte_d = i_rd_data_io;
            3'b100:  tx_byte_d = i_rd_data_smi;
            default: tx_byte_d = 8'h00;
          endcase
          tx_load_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ioc       = ioc_q;
  assign o_data_out  = data_q;
  assign o_cs_sys    = cs_q[0];
  assign o_cs_io     = cs_q[1];
  assign o_cs_smi    = cs_q[2];
  assign o_fetch_cmd = fetch_q;
  assign o_load_cmd  = load_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_tx_load   = tx_load_q;
  assign o_err_count = err_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: table of frames plus hand-written abort, extra-byte,
// saturation and reset-mid-read sequences; strobes are checked against a queue.
module tb_spi_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_active;
  logic [7:0] rd_sys, rd_io, rd_smi;
  logic [4:0] o_ioc;
  logic [7:0] o_data_out;
  logic       o_cs_sys, o_cs_io, o_cs_smi;
  logic       o_fetch_cmd, o_load_cmd;
  logic [7:0] o_tx_byte;
  logic       o_tx_load;
  logic [7:0] o_err_count;
  logic [2:0] o_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int err_model = 0;
  logic [9:0] exp_q[$];  // {kind, byte}: kind 1 = load strobe, 2 = tx strobe

  localparam logic [1:0] K_NONE = 2'd0, K_WR = 2'd1, K_RD = 2'd2;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] r_sys;
    logic [7:0] r_io;
    logic [7:0] r_smi;
    logic [2:0] exp_cs;   // {smi, io, sys}
    logic [1:0] kind;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[10];

  spi_cmd_decoder dut (
    .i_sys_clk      (clk),
    .i_rst_b        (rst_b),
    .i_rx_byte      (rx_byte),
    .i_rx_valid     (rx_valid),
    .i_frame_active (frame_active),
    .i_rd_data_sys  (rd_sys),
    .i_rd_data_io   (rd_io),
    .i_rd_data_smi  (rd_smi),
    .o_ioc          (o_ioc),
    .o_data_out     (o_data_out),
    .o_cs_sys       (o_cs_sys),
    .o_cs_io        (o_cs_io),
    .o_cs_smi       (o_cs_smi),
    .o_fetch_cmd    (o_fetch_cmd),
    .o_load_cmd     (o_load_cmd),
    .o_tx_byte      (o_tx_byte),
    .o_tx_load      (o_tx_load),
    .o_err_count    (o_err_count),
    .o_state        (o_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    frame_active = 1'b1;
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    frame_active = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("end_cs", {o_cs_smi, o_cs_io, o_cs_sys}, 0);
    check("end_state", o_state, 0);
    check("end_err", o_err_count, err_model);
    check("end_queue_empty", exp_q.size(), 0);
  endtask

  task automatic bump_err();
    err_model = (err_model == 255) ? 255 : err_model + 1;
  endtask

  // Scoreboard monitor plus per-cycle invariants
  always @(negedge clk) begin
    if (rst_b) begin
      check("fetch_load_excl", {63'd0, o_fetch_cmd & o_load_cmd}, 0);
      check("cs_at_most_one", ($countones({o_cs_smi, o_cs_io, o_cs_sys}) <= 1) ? 1 : 0, 1);
      if (o_load_cmd || o_tx_load) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_strobe: got load=%0b tx=%0b, required none (t=%0t)",
                   o_load_cmd, o_tx_load, $time);
        end else begin
          check("strobe", o_load_cmd ? {K_WR, o_data_out} : {K_RD, o_tx_byte}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_frame(input vec_t v);
    rd_sys = v.r_sys;
    rd_io  = v.r_io;
    rd_smi = v.r_smi;
    start_frame();
    if (v.kind == K_RD) exp_q.push_back({K_RD, v.exp_byte});
    if (v.kind == K_NONE) bump_err();
    send_byte(v.cmd);
    @(negedge clk);
    check("vec_cs", {o_cs_smi, o_cs_io, o_cs_sys}, v.exp_cs);
    check("vec_ioc", o_ioc, v.cmd[4:0]);
    if (v.kind == K_WR) exp_q.push_back({K_WR, v.exp_byte});
    if (v.kind != K_RD) send_byte(v.data);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("vec_cs_held", {o_cs_smi, o_cs_io, o_cs_smi & 1'b0 | o_cs_sys}, v.exp_cs);
    end_frame();
  endtask

  initial begin
    vecs[0] = '{8'h06, 8'h5A, 8'h00, 8'h00, 8'h00, 3'b001, K_WR,   8'h5A};
    vecs[1] = '{8'hA3, 8'h00, 8'h00, 8'hC4, 8'h00, 3'b010, K_RD,   8'hC4};
    vecs[2] = '{8'h3F, 8'h81, 8'h00, 8'h00, 8'h00, 3'b010, K_WR,   8'h81};
    vecs[3] = '{8'h5F, 8'hFF, 8'h00, 8'h00, 8'h00, 3'b100, K_WR,   8'hFF};
    vecs[4] = '{8'h80, 8'h00, 8'h12, 8'h34, 8'h56, 3'b001, K_RD,   8'h12};
    vecs[5] = '{8'hC7, 8'h00, 8'h12, 8'h34, 8'h56, 3'b100, K_RD,   8'h56};
    vecs[6] = '{8'h60, 8'h77, 8'h00, 8'h00, 8'h00, 3'b000, K_NONE, 8'h00};
    vecs[7] = '{8'hE1, 8'h99, 8'h11, 8'h22, 8'h33, 3'b000, K_NONE, 8'h00};
    vecs[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'b001, K_WR,   8'h00};
    vecs[9] = '{8'hB5, 8'h00, 8'h01, 8'hAA, 8'h02, 3'b010, K_RD,   8'hAA};

    rst_b = 1'b0; rx_byte = '0; rx_valid = 1'b0; frame_active = 1'b0;
    rd_sys = '0; rd_io = '0; rd_smi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {o_ioc, o_data_out, o_cs_sys, o_cs_io, o_cs_smi, o_fetch_cmd,
                            o_load_cmd, o_tx_byte, o_tx_load, o_err_count}, 0);
    check("reset_state", o_state, 0);
    rst_b = 1'b1;

    for (int i = 0; i < 10; i++) run_frame(vecs[i]);

    // Read latency: fetch in t+1 only, tx strobe in t+3 only
    rd_io = 8'hC4; rd_sys = 8'h00; rd_smi = 8'h00;
    start_frame();
    exp_q.push_back({K_RD, 8'hC4});
    send_byte(8'hA3);
    @(negedge clk);
    check("rd_t1_fetch", o_fetch_cmd, 1);
    check("rd_t1_cs_io", o_cs_io, 1);
    check("rd_t1_tx", o_tx_load, 0);
    @(negedge clk);
    check("rd_t2_fetch", o_fetch_cmd, 0);
    check("rd_t2_tx", o_tx_load, 0);
    @(negedge clk);
    check("rd_t3_tx", o_tx_load, 1);
    check("rd_t3_byte", o_tx_byte, 8'hC4);
    @(negedge clk);
    check("rd_t4_tx", o_tx_load, 0);
    check("rd_t4_state", o_state, 4);
    end_frame();

    // Abort a write before its data byte
    start_frame();
    send_byte(8'h05);
    @(negedge clk);
    check("abort_cs_sys", o_cs_sys, 1);
    check("abort_state_dataw", o_state, 1);
    end_frame();

    // Bytes while chip-select is low are ignored
    send_byte(8'h06);
    send_byte(8'h44);
    @(negedge clk);
    check("idle_rx_state", o_state, 0);
    check("idle_rx_cs", {o_cs_smi, o_cs_io, o_cs_sys}, 0);

    // Frame ends in READ_F: tx strobe suppressed
    start_frame();
    send_byte(8'hA3);
    frame_active = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rd_abort_state", o_state, 0);
    check("rd_abort_queue", exp_q.size(), 0);

    // Extra bytes after write data produce no further load
    start_frame();
    exp_q.push_back({K_WR, 8'h11});
    send_byte(8'h06);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    end_frame();
    check("extra_data_out", o_data_out, 8'h11);

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      start_frame();
      bump_err();
      send_byte(8'h60);
      @(posedge clk); #1;
      frame_active = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("sat_err_step", o_err_count, err_model);
    end
    check("sat_err_final", o_err_count, 8'hFF);

    // Reset in cycle t+1 of a read
    rd_io = 8'h5C;
    start_frame();
    send_byte(8'hA3);
    rst_b = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    frame_active = 1'b0;
    rst_b = 1'b1;
    err_model = 0;
    @(negedge clk);
    check("rst_mid_outputs", {o_ioc, o_data_out, o_cs_sys, o_cs_io, o_cs_smi, o_fetch_cmd,
                              o_load_cmd, o_tx_byte, o_tx_load, o_err_count}, 0);
    check("rst_mid_state", o_state, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_mid_no_tx", exp_q.size(), 0);
    check("rst_mid_err", o_err_count, err_model);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
